// File: rtl/bec_status_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : bec_status_tx                                               |
// | Purpose  : Publishes BEC progress codes to the Caravel pads. Events    |
// |            from the BEC core are queued in a small FIFO. Each event is |
// |            shown on chk_out/id_out for HOLD_CYCLES. A GAP_CYCLES zero  |
// |            gap separates codes so repeated identical codes still read  |
// |            as distinct events. DONE_CODE locks the block until reset.  |
// | Option   : define BEC_STATUS_UART_EN to build an 8N1 serializer that   |
// |            sends id, code[15:8], code[7:0] on uart_tx per shown code.  |
// | Ports    : wb_clk_i/wb_rst_i - clock, synchronous active-high reset    |
// |            en               - pad drive and event capture enable      |
// |            evt_stb/code/id  - one-cycle event strobe and payload      |
// |            chk_out/id_out   - to io_out[31:16] / io_out[15:8]         |
// |            io_oeb           - to io_oeb[31:8], active-low, registered |
// |            busy/done        - activity flag / terminal code reached   |
// |            drop_cnt         - saturating count of overflow drops      |
// |            uart_tx          - serial status stream (idle high)        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module bec_status_tx #(
   parameter int          DEPTH        = 4,
   parameter int          HOLD_CYCLES  = 64,
   parameter int          GAP_CYCLES   = 2,
   parameter logic [15:0] DONE_CODE    = 16'hABFF,
   parameter int          CLKS_PER_BIT = 4167
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        en,
   input  logic        evt_stb,
   input  logic [15:0] evt_code,
   input  logic [7:0]  evt_id,
   output logic [15:0] chk_out,
   output logic [7:0]  id_out,
   output logic [23:0] io_oeb,
   output logic        busy,
   output logic        done,
   output logic [7:0]  drop_cnt,
   output logic        uart_tx
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW   = AW + 1;
   localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SHOW = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [23:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [23:0]     head;
   logic            fifo_full;
   logic            timer_zero;
   logic            accept;
   logic            push;
   logic            drop;
   logic            pop;
   logic            uart_free;

   assign head       = mem[rd_ptr];
   assign fifo_full  = (count == FULL_CNT);
   assign timer_zero = (timer == '0);

   // Fullness is judged on the pre-pop count, so a full FIFO drops even
   // when the FSM pops on the same edge.
   assign accept = evt_stb && en && (state != S_DONE);
   assign push   = accept && !fifo_full;
   assign drop   = accept && fifo_full;

   // A pop always coincides with loading a new code into SHOW.
   always_comb begin
      pop = 1'b0;
      if (count != '0) begin
         if (state == S_IDLE)
            pop = 1'b1;
         else if ((state == S_GAP) && timer_zero)
            pop = 1'b1;
      end
   end

   assign busy = (count != '0) || (state != S_IDLE);
   assign done = (state == S_DONE);

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge wb_clk_i) begin
      if (push)
         mem[wr_ptr] <= {evt_id, evt_code};
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (state == S_DONE) begin
         // Terminal state: anything still queued is discarded.
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // --------------------------------------------------- pad enable / drops
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         io_oeb   <= '1;
         drop_cnt <= '0;
      end else begin
         io_oeb <= en ? 24'h000000 : 24'hFFFFFF;
         if (drop && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state   <= S_IDLE;
         timer   <= '0;
         chk_out <= '0;
         id_out  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  {id_out, chk_out} <= head;
                  timer             <= TW'(HOLD_CYCLES - 1);
                  state             <= S_SHOW;
               end
            end
            S_SHOW: begin
               // Timer parks at zero while a serial burst is still running.
               if (!timer_zero) begin
                  timer <= timer - TW'(1);
               end else if (uart_free) begin
                  if (chk_out == DONE_CODE) begin
                     state <= S_DONE;
                  end else begin
                     chk_out <= '0;
                     id_out  <= '0;
                     timer   <= TW'(GAP_CYCLES - 1);
                     state   <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (!timer_zero) begin
                  timer <= timer - TW'(1);
               end else if (pop) begin
                  {id_out, chk_out} <= head;
                  timer             <= TW'(HOLD_CYCLES - 1);
                  state             <= S_SHOW;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef BEC_STATUS_UART_EN
   // ------------------------------------------------------ 8N1 serializer
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [BW-1:0] baud;
   logic [3:0]    bit_idx;
   logic [1:0]    frame;
   logic          active;
   logic [9:0]    shreg;     // {stop, data[7:0], start}; bit 0 is on the line
   logic [15:0]   pend;      // bytes still to send after the current frame
   logic          bit_end;
   logic          last_tick;

   assign bit_end   = active && (baud == BW'(CLKS_PER_BIT - 1));
   assign last_tick = bit_end && (bit_idx == 4'd9) && (frame == 2'd2);
   // SHOW may leave on the very edge the final stop bit completes.
   assign uart_free = !active || last_tick;
   assign uart_tx   = shreg[0];

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         active  <= 1'b0;
         shreg   <= '1;
         pend    <= '0;
         baud    <= '0;
         bit_idx <= '0;
         frame   <= '0;
      end else if (pop) begin
         active  <= 1'b1;
         shreg   <= {1'b1, head[23:16], 1'b0};
         pend    <= head[15:0];
         baud    <= '0;
         bit_idx <= '0;
         frame   <= '0;
      end else if (active) begin
         if (bit_end) begin
            baud <= '0;
            if (bit_idx == 4'd9) begin
               if (frame == 2'd2) begin
                  active <= 1'b0;
                  shreg  <= '1;
               end else begin
                  frame   <= frame + 2'd1;
                  bit_idx <= '0;
                  shreg   <= {1'b1, pend[15:8], 1'b0};
                  pend    <= {pend[7:0], 8'h00};
               end
            end else begin
               bit_idx <= bit_idx + 4'd1;
               shreg   <= {1'b1, shreg[9:1]};
            end
         end else begin
            baud <= baud + BW'(1);
         end
      end
   end
`else
   logic unused_cpb;

   assign uart_free  = 1'b1;
   assign uart_tx    = 1'b1;
   assign unused_cpb = ^CLKS_PER_BIT;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bec_status_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_bec_status_tx                                            |
// | Purpose  : Self-checking bench for bec_status_tx. Expected events are  |
// |            queued as they are strobed in; a monitor pops and compares  |
// |            each code as it appears on the pins, and checks hold length,|
// |            gap length, pad enable and (with BEC_STATUS_UART_EN) the    |
// |            serial bytes.                                               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_bec_status_tx;

   localparam int          DEPTH = 4;
   localparam int          HOLD  = 64;
   localparam int          GAP   = 2;
   localparam int          CPB   = 16;
   localparam logic [15:0] DONE_CODE = 16'hABFF;
`ifdef BEC_STATUS_UART_EN
   localparam int HOLD_EFF = (30 * CPB > HOLD) ? 30 * CPB : HOLD;
`else
   localparam int HOLD_EFF = HOLD;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        evt_stb = 1'b0;
   logic [15:0] evt_code = '0;
   logic [7:0]  evt_id = '0;
   logic [15:0] chk_out;
   logic [7:0]  id_out;
   logic [23:0] io_oeb;
   logic        busy;
   logic        done;
   logic [7:0]  drop_cnt;
   logic        uart_tx;

   int errors = 0;
   int checks = 0;

   logic [23:0] sb [$];   // expected {id, code} in display order
   logic [7:0]  uq [$];   // expected serial bytes

   logic [15:0] ov_codes [6] = '{16'hAB41, 16'hAB42, 16'hAB43, 16'hAB44, 16'hAB51, 16'hAB30};

   always #5 clk = ~clk;

   bec_status_tx #(
      .DEPTH       (DEPTH),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .DONE_CODE   (DONE_CODE),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .en       (en),
      .evt_stb  (evt_stb),
      .evt_code (evt_code),
      .evt_id   (evt_id),
      .chk_out  (chk_out),
      .id_out   (id_out),
      .io_oeb   (io_oeb),
      .busy     (busy),
      .done     (done),
      .drop_cnt (drop_cnt),
      .uart_tx  (uart_tx)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------- monitor
   logic [23:0] prev_val = '0;
   int          run = 0;
   int          zrun = 0;
   bit          gap_ok = 1'b0;
   int          rx_cnt = -1;
   int          rx_low = 0;
   logic [9:0]  rx_bits = '0;
   logic [23:0] exp_ev;

   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         prev_val = '0;
         run      = 0;
         zrun     = 0;
         gap_ok   = 1'b0;
         rx_cnt   = -1;
         uq.delete();
      end else begin
         check("io_oeb", {8'h00, io_oeb}, en ? 32'h0 : 32'h00FFFFFF);
         if (chk_out != 16'h0 && prev_val[15:0] == 16'h0) begin
            if (gap_ok)
               check("gap_len", zrun, GAP);
            if (sb.size() == 0) begin
               check("unexpected_event", {8'h00, id_out, chk_out}, 32'h0);
            end else begin
               exp_ev = sb.pop_front();
               check("event", {8'h00, id_out, chk_out}, {8'h00, exp_ev});
            end
            uq.push_back(id_out);
            uq.push_back(chk_out[15:8]);
            uq.push_back(chk_out[7:0]);
            run = 1;
         end else if (chk_out != 16'h0) begin
            check("hold_stable", {8'h00, id_out, chk_out}, {8'h00, prev_val});
            run++;
         end else if (prev_val[15:0] != 16'h0) begin
            check("hold_len", run, HOLD_EFF);
            zrun   = 1;
            gap_ok = 1'b1;
         end else begin
            zrun++;
         end
         if (!busy)
            gap_ok = 1'b0;
         prev_val = {id_out, chk_out};
`ifdef BEC_STATUS_UART_EN
         if (rx_cnt < 0) begin
            if (uart_tx == 1'b0) begin
               rx_cnt = 0;
               rx_low = 1;
            end
         end else begin
            rx_cnt++;
            if (rx_cnt < CPB && uart_tx == 1'b0)
               rx_low++;
            if ((rx_cnt % CPB) == CPB / 2)
               rx_bits[rx_cnt / CPB] = uart_tx;
            if (rx_cnt == 10 * CPB - 1) begin
               check("uart_start_len", rx_low, CPB);
               check("uart_stop", rx_bits[9], 1);
               if (uq.size() == 0)
                  check("uart_unexpected", rx_bits[8:1], 32'h100);
               else
                  check("uart_byte", rx_bits[8:1], uq.pop_front());
               rx_cnt = -1;
            end
         end
`else
         check("uart_idle", uart_tx, 1);
`endif
      end
   end

   // ---------------------------------------------------------- stimulus
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic strobe(input logic [7:0] id, input logic [15:0] code);
      evt_stb  = 1'b1;
      evt_id   = id;
      evt_code = code;
      tick();
      evt_stb  = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (!(busy === 1'b0 && chk_out === 16'h0) && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(n >= budget), 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_chk", chk_out, 0);
      check("rst_id", id_out, 0);
      check("rst_oeb", io_oeb, 32'h00FFFFFF);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_uart", uart_tx, 1);
      rst = 1'b0;
      en  = 1'b1;
      tick();
      check("oeb_enabled", io_oeb, 0);

      // Basic sequence: latency of one edge, then AB41 200 cycles later
      sb.push_back({8'h01, 16'hAB30});
      strobe(8'h01, 16'hAB30);
      check("lat_before", chk_out, 0);
      check("busy_queued", busy, 1);
      tick();
      check("lat_after", {id_out, chk_out}, {8'h01, 16'hAB30});
      repeat (198) tick();
      sb.push_back({8'h02, 16'hAB41});
      strobe(8'h02, 16'hAB41);
      wait_idle("basic_timeout", 3000);

      // Repeated identical code: busy must not drop between them
      sb.push_back({8'h03, 16'hAB42});
      sb.push_back({8'h03, 16'hAB42});
      strobe(8'h03, 16'hAB42);
      check("rep_busy0", busy, 1);
      strobe(8'h03, 16'hAB42);
      n = 1;
      while (busy === 1'b1 && n < 5000) begin
         n++;
         tick();
      end
      check("rep_busy_run", n, 2 * (HOLD_EFF + GAP) + 1);
      check("rep_idle_chk", chk_out, 0);

      // Overflow: six back-to-back strobes into a four-deep FIFO
      for (int i = 0; i < 6; i++) begin
         if (i < 5)
            sb.push_back({8'(8'h10 + i), ov_codes[i]});
         evt_stb  = 1'b1;
         evt_id   = 8'(8'h10 + i);
         evt_code = ov_codes[i];
         tick();
      end
      evt_stb = 1'b0;
      check("ovf_drop", drop_cnt, 1);
      // Pad release mid-SHOW must not disturb the sequence
      repeat (20) tick();
      en = 1'b0;
      repeat (5) tick();
      check("en_low_still_busy", busy, 1);
      en = 1'b1;
      wait_idle("ovf_timeout", 6000);
      check("ovf_drop_final", drop_cnt, 1);
      check("ovf_sb_empty", sb.size(), 0);

      // Reset in the middle of SHOW, with the hold timer at 30
      sb.push_back({8'h20, 16'hAB43});
      strobe(8'h20, 16'hAB43);
      tick();
      check("midshow_chk", chk_out, 16'hAB43);
      repeat (33) tick();
      rst = 1'b1;
      tick();
      check("mrst_chk", chk_out, 0);
      check("mrst_id", id_out, 0);
      check("mrst_oeb", io_oeb, 32'h00FFFFFF);
      check("mrst_busy", busy, 0);
      check("mrst_uart", uart_tx, 1);
      check("mrst_drop", drop_cnt, 0);
      rst = 1'b0;
      tick();

      // Terminal code: later events are ignored, pins locked
      sb.push_back({8'h30, DONE_CODE});
      strobe(8'h30, DONE_CODE);
      n = 0;
      while (chk_out !== DONE_CODE && n < 100) begin
         tick();
         n++;
      end
      check("term_show_timeout", 32'(n >= 100), 0);
      strobe(8'h31, 16'hAB30);
      n = 0;
      while (done !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      check("term_done_timeout", 32'(n >= 2000), 0);
      bad = 0;
      evt_id   = 8'h32;
      evt_code = 16'hAB41;
      for (int i = 0; i < 1000; i++) begin
         evt_stb = (i == 10);
         if (chk_out !== DONE_CODE || id_out !== 8'h30 || done !== 1'b1 || busy !== 1'b1)
            bad++;
         tick();
      end
      evt_stb = 1'b0;
      check("term_hold_bad_cycles", bad, 0);
      check("term_drop", drop_cnt, 0);

      // Only reset leaves DONE
      rst = 1'b1;
      tick();
      check("final_rst_done", done, 0);
      check("final_rst_chk", chk_out, 0);
      rst = 1'b0;
      tick();
      check("sb_left", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bec_status_tx.md
Name: bec_status_tx

Overview:
- User-project block that publishes BEC progress codes to the pads: `checkbits` on mprj_io[31:16] and test id on mprj_io[15:8].
- It is the hardware originator of the status codes the Caravel bench decodes: AB30, AB41, AB42, AB43, AB44, AB51, ABFF.
- Events from the BEC core are queued and each is held on the pins long enough to be sampled.
- A zero gap between events lets repeated identical codes register as distinct events.

Parameters:
- DEPTH, 4: status FIFO entries (power of two, ≥2).
- HOLD_CYCLES, 64: cycles each code stays on the pins (≥1).
- GAP_CYCLES, 2: cycles of 16'h0000 / 8'h00 driven between codes (≥1).
- DONE_CODE, 16'hABFF: terminal code that locks the block.
- CLKS_PER_BIT, 4167: UART bit period in clocks (40 MHz / 9600); used only with the optional feature.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- en  in  1  enables pad drive and event capture.
- evt_stb  in  1  one-cycle strobe: new status event.
- evt_code  in  16  status code, sampled with evt_stb.
- evt_id  in  8  test id, sampled with evt_stb.
- chk_out  out  16  to io_out[31:16].
- id_out  out  8  to io_out[15:8].
- io_oeb  out  24  to io_oeb[31:8]; active-low.
- busy  out  1  FIFO non-empty or state ≠ IDLE.
- done  out  1  terminal code reached.
- drop_cnt  out  8  dropped events, saturating.
- uart_tx  out  1  serial status stream.

Behaviour:
- Reset values:
  - chk_out = 0, id_out = 0, io_oeb = 24'hFFFFFF.
  - busy = 0, done = 0, drop_cnt = 0, uart_tx = 1.
  - FIFO empty, state IDLE.
- io_oeb is all 0 while en = 1, and all 1 otherwise (registered, 1-cycle lag).
- Capture rule:
  - evt_stb && en && state ≠ DONE && FIFO not full: write {evt_id, evt_code} at that edge.
  - evt_stb && en && FIFO full: event discarded, drop_cnt += 1, saturating at 255.
  - Events in state DONE, or with en = 0: ignored and not counted.
- FIFO: circular buffer with pointer wrap at DEPTH and an explicit count.
  - A push and pop on the same edge is legal, count is unchanged.
  - When full, the push is checked against the pre-pop count, so a full FIFO drops even if a pop occurs that edge.
- States:
  - IDLE: when FIFO non-empty, pop and load chk_out/id_out -> SHOW, timer = HOLD_CYCLES-1. Latency: strobe at edge N into an empty FIFO in IDLE, value visible after edge N+1.
  - SHOW: timer counts down. When the timer reaches 0 (and, with UART, the serializer is idle):
    - if the shown code == DONE_CODE -> DONE;
    - otherwise drive 0 on chk_out/id_out -> GAP, timer = GAP_CYCLES-1.
  - GAP: at timer 0:
    - FIFO non-empty: pop/load -> SHOW;
    - else -> IDLE with outputs left at 0.
  - DONE: chk_out = DONE_CODE and id_out stay held, done = 1. Leaves only by reset; remaining FIFO contents are discarded.
- Reset mid-operation: all state and outputs return to reset values on the next edge, and any UART frame is aborted with the line high.
- en falling mid-SHOW: the sequence continues, only the pad drive is released.

Optional Feature:
- Macro: BEC_STATUS_UART_EN.
- Defined: on entry to SHOW, three 8N1 frames are sent on uart_tx, LSB first, CLKS_PER_BIT per bit.
  - Frame order: id, code[15:8], code[7:0].
  - SHOW exits only when the hold timer has expired and all three frames are complete.
- Undefined: no serializer is built, uart_tx is tied 1, and SHOW timing depends on HOLD_CYCLES only.

Test Plan:
- Basic sequence: reset, en = 1, strobe {id 8'h01, code AB30}, then AB41 spaced 200 cycles apart.
  - chk_out = AB30 after 1 cycle, held 64 cycles, then 0000 for 2 cycles, then AB41.
  - io_oeb = 0 throughout.
- Repeated code: two AB42 strobes on consecutive cycles -> AB42, 2-cycle 0000 gap, AB42 again; busy stays 1 across both.
- Overflow: 6 strobes in 6 cycles (AB41..AB44, AB51, AB30) with DEPTH = 4.
  - First 5 are shown in order: the first is popped to SHOW the cycle after its strobe, freeing a slot.
  - drop_cnt = 1.
- Terminal: strobe ABFF, then AB30 after ABFF is shown.
  - done = 1 and chk_out stays ABFF for 1000 cycles.
  - AB30 is ignored and drop_cnt is unchanged.
- Reset mid-SHOW: assert wb_rst_i at timer 30 -> next edge chk_out = 0, io_oeb = FFFFFF, FIFO empty, uart_tx = 1.
- With BEC_STATUS_UART_EN and CLKS_PER_BIT = 16: event {8'h07, AB51} produces bytes 07, AB, 51.
  - Start bit is low for 16 cycles on each frame.
  - SHOW lasts 480 cycles, exceeding HOLD_CYCLES = 64.
